mem_result_checker: RTL and testbench
=====================================

// Module: mem_result_checker
// PURPOSE
//  Synthesisable, parametrised successor to the fixed 1000-cycle / 32-word end-of-test dmem dump-and-compare.
//  Runs the DUT for a programmable cycle budget, or stops early on a halt request.
//  Then reads WORDS data-memory words over a 1-cycle sync read port and compares each against an expected-value ROM under a per-bit care mask.
//  Streams each mismatch out over a valid/ready log port. Sits beside cpu/dmem in the SoC test wrapper.
// PARAMETERS
//  DATA_W      32    word width compared (multiple of 8)
//  WORDS       32    number of words dumped and checked, >=1
//  ADDR_W      5     word-index width, 2**ADDR_W >= WORDS
//  CYCLE_LIMIT 1000  DUT run budget in clocks, >=1
//  CNT_W       16    cycle-counter width, 2**CNT_W > CYCLE_LIMIT
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset      in   1        reset, asynchronous, active-low
//  start      in   1        pulse: begin run (honoured in IDLE or DONE only)
//  halt       in   1        DUT requests early end of run (sampled in RUN only)
//  dut_en     out  1        DUT may advance; high only in RUN
//  rd_en      out  1        memory/ROM read strobe
//  rd_addr    out  ADDR_W   word index for dmem and expected ROM (shared)
//  rd_data    in   DATA_W   dmem word, valid 1 clk after rd_en
//  exp_data   in   DATA_W   expected word, valid 1 clk after rd_en
//  exp_care   in   DATA_W   care mask, 1 = bit compared; same timing as exp_data
//  mis_valid  out  1        mismatch record available
//  mis_ready  in   1        log sink accepts record
//  mis_idx    out  ADDR_W   failing word index
//  mis_got    out  DATA_W   value read from dmem
//  mis_exp    out  DATA_W   expected value
//  done       out  1        check complete, held until start or reset
//  pass       out  1        done && fail_count==0
//  timed_out  out  1        run ended by CYCLE_LIMIT, not halt
//  fail_count out  ADDR_W+1 number of mismatching words
// BEHAVIOUR
//  Reset: state IDLE, every output 0, counters 0; async assert drops mis_valid/dut_en immediately.
//  FSM: IDLE -start-> RUN -(halt | cnt==CYCLE_LIMIT-1)-> READ -> CMP -> (mismatch ? REPORT : next) ; REPORT -mis_ready-> next.
//  next: idx==WORDS-1 -> DONE, else idx+1 -> READ. DONE -start-> RUN (clears fail_count, done, pass, timed_out, idx).
//  RUN: start sampled at edge k -> dut_en=1 for cycles k+1..k+CYCLE_LIMIT (exactly CYCLE_LIMIT clocks absent halt).
//  halt in RUN: dut_en deasserts the following cycle; timed_out=0.
//  halt and limit in the same cycle: halt wins, timed_out=0.
//  READ: rd_en=1, rd_addr=idx for one cycle. CMP: mismatch = |((rd_data ^ exp_data) & exp_care).
//  Mismatch: fail_count+1 in CMP; REPORT drives mis_valid=1 with idx/got/exp registered.
//  mis_* stable while mis_valid && !mis_ready; mis_valid never drops without handshake except on reset.
//  Throughput: 2 clk/word clean, 3+ with mismatch (backpressure stalls indefinitely; no record dropped).
//  dut_en=0 in every state except RUN; DUT memory is frozen during the dump.
//  start outside IDLE/DONE ignored; halt outside RUN ignored.
//  done/pass/timed_out set in the cycle DONE is entered and held.
//  Arithmetic: cycle counter CNT_W unsigned, no wrap (stops at limit); fail_count max WORDS, cannot overflow.
// STRUCTURE
//  mem_check_pkg (`include header): state encodings IDLE/RUN/READ/CMP/REPORT/DONE, width helper constants.
//  Sub-module run_timer: load/count/expire cycle counter (CNT_W, CYCLE_LIMIT); FSM and compare datapath stay in top.
// TESTING
//  1 All match, no halt, LIMIT=1000: start -> dut_en high 1000 clks; done, pass=1, timed_out=1, fail_count=0, mis_valid never 1.
//  2 Early halt at cycle 37: dut_en low at 38; timed_out=0; dump of 32 words still completes with pass=1.
//  3 Words 3 and 31 wrong (0xDEADBEEF vs 0): two records idx=3 then idx=31, got/exp correct; fail_count=2, pass=0.
//  4 Care mask 0xFFFF0000, low half differs on word 5: no mismatch, pass=1. High bit 31 differs: record idx=5.
//  5 mis_ready low for 20 clks on a record: mis_* stable, rd_en quiet, no lost records; resumes on ready.
//  6 reset low mid-dump at idx=10: all outputs 0 asynchronously; a new start gives a full clean run with fail_count restarted.
//    Also: halt and limit in same cycle -> timed_out=0; start during RUN ignored.

Source files
------------

// File: rtl/mem_result_checker_pkg.sv
// mem_check_pkg: state encoding and width helpers shared by mem_result_checker
package mem_check_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_READ,
        S_CMP,
        S_REPORT,
        S_DONE
    } state_t;

    localparam int STATE_W = $bits(state_t);

endpackage

// File: rtl/mem_result_checker_run_timer.sv
// run_timer: DUT run-budget counter, reloads on load, saturates at CYCLE_LIMIT-1
module run_timer #(
    parameter int CNT_W       = 16,
    parameter int CYCLE_LIMIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = cnt_q == CNT_W'(CYCLE_LIMIT - 1);

    // restart on load, otherwise count while enabled and hold once the last budget cycle is reached
    always_comb cnt_d = load ? '0 : (en && !expire) ? cnt_q + CNT_W'(1) : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/mem_result_checker.sv
// mem_result_checker: timed DUT run, then masked dmem-vs-expected dump with a mismatch log stream
module mem_result_checker
    import mem_check_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int WORDS       = 32,
    parameter int ADDR_W      = 5,
    parameter int CYCLE_LIMIT = 1000,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    output logic              dut_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] exp_care,
    output logic              mis_valid,
    input  logic              mis_ready,
    output logic [ADDR_W-1:0] mis_idx,
    output logic [DATA_W-1:0] mis_got,
    output logic [DATA_W-1:0] mis_exp,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [ADDR_W:0]   fail_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, mis_idx_q, mis_idx_d;
    logic [ADDR_W:0]   fail_q, fail_d;
    logic [DATA_W-1:0] mis_got_q, mis_got_d, mis_exp_q, mis_exp_d;
    logic              dut_en_q, dut_en_d, rd_en_q, rd_en_d, mis_valid_q, mis_valid_d;
    logic              done_q, done_d, pass_q, pass_d, timed_out_q, timed_out_d;
    logic              hit_limit_q, hit_limit_d;
    logic              go, expire, mismatch, last, adv, run;

    assign go       = start && (state_q == S_IDLE || state_q == S_DONE);
    assign run      = state_q == S_RUN;
    assign mismatch = |((rd_data ^ exp_data) & exp_care);
    assign last     = idx_q == ADDR_W'(WORDS - 1);
    assign adv      = (state_q == S_CMP && !mismatch) || (state_q == S_REPORT && mis_ready);

    run_timer #(.CNT_W(CNT_W), .CYCLE_LIMIT(CYCLE_LIMIT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (go),
        .en     (run),
        .expire (expire)
    );

    assign dut_en     = dut_en_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = idx_q;
    assign mis_valid  = mis_valid_q;
    assign mis_idx    = mis_idx_q;
    assign mis_got    = mis_got_q;
    assign mis_exp    = mis_exp_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timed_out  = timed_out_q;
    assign fail_count = fail_q;

    // next-state and registered-output logic; strobes default low, everything else holds
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fail_d      = fail_q;
        mis_idx_d   = mis_idx_q;
        mis_got_d   = mis_got_q;
        mis_exp_d   = mis_exp_q;
        mis_valid_d = mis_valid_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        hit_limit_d = hit_limit_q;
        dut_en_d    = 1'b0;
        rd_en_d     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (go) begin
                state_d     = S_RUN;
                dut_en_d    = 1'b1;
                idx_d       = '0;
                fail_d      = '0;
                done_d      = 1'b0;
                pass_d      = 1'b0;
                timed_out_d = 1'b0;
                hit_limit_d = 1'b0;
            end
            S_RUN: if (halt || expire) begin
                state_d     = S_READ;
                rd_en_d     = 1'b1;
                hit_limit_d = !halt;
            end else begin
                dut_en_d = 1'b1;
            end
            S_READ: state_d = S_CMP;
            S_CMP: if (mismatch) begin
                state_d     = S_REPORT;
                fail_d      = fail_q + (ADDR_W+1)'(1);
                mis_valid_d = 1'b1;
                mis_idx_d   = idx_q;
                mis_got_d   = rd_data;
                mis_exp_d   = exp_data;
            end
            S_REPORT: if (mis_ready) mis_valid_d = 1'b0;
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            if (last) begin
                state_d     = S_DONE;
                done_d      = 1'b1;
                pass_d      = fail_q == '0;
                timed_out_d = hit_limit_q;
            end else begin
                state_d = S_READ;
                idx_d   = idx_q + ADDR_W'(1);
                rd_en_d = 1'b1;
            end
        end
    end

    // all state; async reset clears every output at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            fail_q      <= '0;
            mis_idx_q   <= '0;
            mis_got_q   <= '0;
            mis_exp_q   <= '0;
            mis_valid_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            hit_limit_q <= 1'b0;
            dut_en_q    <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fail_q      <= fail_d;
            mis_idx_q   <= mis_idx_d;
            mis_got_q   <= mis_got_d;
            mis_exp_q   <= mis_exp_d;
            mis_valid_q <= mis_valid_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            hit_limit_q <= hit_limit_d;
            dut_en_q    <= dut_en_d;
            rd_en_q     <= rd_en_d;
        end
    end

endmodule

// File: tb/tb_mem_result_checker.sv
// tb_mem_result_checker: directed scenario bench for mem_result_checker
module tb_mem_result_checker;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, halt = 1'b0, mis_ready = 1'b1;
    logic        dut_en, rd_en, mis_valid, done, pass, timed_out;
    logic [4:0]  rd_addr, mis_idx;
    logic [5:0]  fail_count;
    logic [31:0] rd_data = '0, exp_data = '0, exp_care = '0, mis_got, mis_exp;
    logic [85:0] outs;

    logic [31:0] dmem [32];
    logic [31:0] erom [32];
    logic [31:0] crom [32];
    logic [4:0]  q_idx [$];
    logic [31:0] q_got [$];
    logic [31:0] q_exp [$];
    int          total = 0, bad = 0, en_cnt;

    mem_result_checker dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .dut_en(dut_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .exp_data(exp_data),
        .exp_care(exp_care), .mis_valid(mis_valid), .mis_ready(mis_ready),
        .mis_idx(mis_idx), .mis_got(mis_got), .mis_exp(mis_exp), .done(done),
        .pass(pass), .timed_out(timed_out), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    assign outs = {dut_en, rd_en, mis_valid, done, pass, timed_out, fail_count,
                   rd_addr, mis_idx, mis_got, mis_exp};

    always @(posedge clk)
        if (rd_en) begin
            rd_data  <= dmem[rd_addr];
            exp_data <= erom[rd_addr];
            exp_care <= crom[rd_addr];
        end

    task automatic fill_clean;
        for (int i = 0; i < 32; i++) begin
            dmem[i] = 32'hA5A5_0000 | i;
            erom[i] = 32'hA5A5_0000 | i;
            crom[i] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic run_to_done(input int halt_at, input int restart_at, input int stall,
                               input logic [4:0] s_idx, input logic [31:0] s_got,
                               input logic [31:0] s_exp);
        int  guard;
        bit  stalled;
        q_idx.delete();
        q_got.delete();
        q_exp.delete();
        en_cnt    = 0;
        guard     = 0;
        stalled   = 0;
        mis_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        do begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            halt  = 1'b0;
            if (dut_en) begin
                en_cnt++;
                if (en_cnt == halt_at) halt = 1'b1;
                if (en_cnt == restart_at) start = 1'b1;
            end
            if (mis_valid && stall > 0 && !stalled) begin
                stalled   = 1;
                mis_ready = 1'b0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    guard++;
                    total++;
                    if (mis_valid !== 1'b1 || rd_en !== 1'b0 || mis_idx !== s_idx ||
                        mis_got !== s_got || mis_exp !== s_exp) begin
                        bad++;
                        $display("FAIL stall_hold cyc=%0d: valid=%b rd_en=%b idx=%0d got=%h exp=%h, want valid=1 rd_en=0 idx=%0d got=%h exp=%h",
                                 i, mis_valid, rd_en, mis_idx, mis_got, mis_exp, s_idx, s_got, s_exp);
                    end
                end
                mis_ready = 1'b1;
            end
            if (mis_valid && mis_ready) begin
                q_idx.push_back(mis_idx);
                q_got.push_back(mis_got);
                q_exp.push_back(mis_exp);
            end
        end while (!done && guard < 5000);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL run_timeout: done=%b after %0d clks, want done=1", done, guard);
        end
    endtask

    task automatic test_reset;
        #3;
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_all_match;
        fill_clean();
        run_to_done(0, 500, 0, '0, '0, '0);
        total += 3;
        if (en_cnt !== 1000) begin bad++; $display("FAIL full_run_len: dut_en clks=%0d, want 1000", en_cnt); end
        if ({done, pass, timed_out, fail_count} !== {3'b111, 6'd0}) begin
            bad++;
            $display("FAIL full_run_flags: done/pass/to/fc=%b/%b/%b/%0d, want 1/1/1/0", done, pass, timed_out, fail_count);
        end
        if (q_idx.size() != 0) begin bad++; $display("FAIL full_run_records: got %0d, want 0", q_idx.size()); end
    endtask

    task automatic test_halt;
        fill_clean();
        run_to_done(37, 0, 0, '0, '0, '0);
        total += 2;
        if (en_cnt !== 37) begin bad++; $display("FAIL halt_len: dut_en clks=%0d, want 37", en_cnt); end
        if ({done, pass, timed_out, fail_count} !== {3'b110, 6'd0}) begin
            bad++;
            $display("FAIL halt_flags: done/pass/to/fc=%b/%b/%b/%0d, want 1/1/0/0", done, pass, timed_out, fail_count);
        end
    endtask

    task automatic test_halt_at_limit;
        fill_clean();
        run_to_done(1000, 0, 0, '0, '0, '0);
        total += 2;
        if (en_cnt !== 1000) begin bad++; $display("FAIL halt_limit_len: dut_en clks=%0d, want 1000", en_cnt); end
        if ({pass, timed_out} !== 2'b10) begin
            bad++;
            $display("FAIL halt_limit_to: pass/to=%b/%b, want 1/0", pass, timed_out);
        end
    endtask

    task automatic test_mismatch;
        fill_clean();
        dmem[3]  = 32'hDEAD_BEEF; erom[3]  = 32'h0;
        dmem[31] = 32'hDEAD_BEEF; erom[31] = 32'h0;
        run_to_done(5, 0, 0, '0, '0, '0);
        total += 2;
        if (q_idx.size() != 2) begin
            bad++;
            $display("FAIL mism_count: records=%0d, want 2", q_idx.size());
        end else begin
            total += 2;
            if (q_idx[0] !== 5'd3 || q_got[0] !== 32'hDEAD_BEEF || q_exp[0] !== 32'h0) begin
                bad++;
                $display("FAIL mism_rec0: idx=%0d got=%h exp=%h, want 3 deadbeef 0", q_idx[0], q_got[0], q_exp[0]);
            end
            if (q_idx[1] !== 5'd31 || q_got[1] !== 32'hDEAD_BEEF || q_exp[1] !== 32'h0) begin
                bad++;
                $display("FAIL mism_rec1: idx=%0d got=%h exp=%h, want 31 deadbeef 0", q_idx[1], q_got[1], q_exp[1]);
            end
        end
        if ({done, pass, fail_count} !== {2'b10, 6'd2}) begin
            bad++;
            $display("FAIL mism_flags: done/pass/fc=%b/%b/%0d, want 1/0/2", done, pass, fail_count);
        end
    endtask

    task automatic test_care_mask;
        fill_clean();
        erom[5] = 32'h1234_0000; dmem[5] = 32'h1234_ABCD; crom[5] = 32'hFFFF_0000;
        run_to_done(3, 0, 0, '0, '0, '0);
        total += 1;
        if (q_idx.size() != 0 || pass !== 1'b1 || fail_count !== 6'd0) begin
            bad++;
            $display("FAIL care_low: records=%0d pass=%b fc=%0d, want 0/1/0", q_idx.size(), pass, fail_count);
        end
        dmem[5] = 32'h9234_ABCD;
        run_to_done(3, 0, 0, '0, '0, '0);
        total += 1;
        if (q_idx.size() != 1 || fail_count !== 6'd1 || pass !== 1'b0) begin
            bad++;
            $display("FAIL care_high_count: records=%0d fc=%0d pass=%b, want 1/1/0", q_idx.size(), fail_count, pass);
        end else begin
            total += 1;
            if (q_idx[0] !== 5'd5 || q_got[0] !== 32'h9234_ABCD || q_exp[0] !== 32'h1234_0000) begin
                bad++;
                $display("FAIL care_high_rec: idx=%0d got=%h exp=%h, want 5 9234abcd 12340000", q_idx[0], q_got[0], q_exp[0]);
            end
        end
    endtask

    task automatic test_backpressure;
        fill_clean();
        dmem[7] = 32'h0BAD_F00D;
        run_to_done(2, 0, 20, 5'd7, 32'h0BAD_F00D, 32'hA5A5_0007);
        total += 1;
        if (q_idx.size() != 1 || fail_count !== 6'd1 || {done, pass} !== 2'b10) begin
            bad++;
            $display("FAIL stall_result: records=%0d fc=%0d done/pass=%b/%b, want 1/1/1/0", q_idx.size(), fail_count, done, pass);
        end
    endtask

    task automatic test_reset_mid_dump;
        int g;
        fill_clean();
        dmem[2] = 32'h0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt  = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (g = 0; g < 200 && !(rd_en && rd_addr == 5'd10); g++) @(negedge clk);
        total += 2;
        if (!(rd_en && rd_addr == 5'd10)) begin bad++; $display("FAIL mid_reach: rd_addr=%0d rd_en=%b, want 10/1", rd_addr, rd_en); end
        if (fail_count !== 6'd1) begin bad++; $display("FAIL mid_count: fc=%0d, want 1", fail_count); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL async_reset: got %h, want 0", outs); end
        @(negedge clk);
        reset = 1'b1;
        fill_clean();
        run_to_done(4, 0, 0, '0, '0, '0);
        total++;
        if ({done, pass, timed_out, fail_count} !== {3'b110, 6'd0} || q_idx.size() != 0) begin
            bad++;
            $display("FAIL post_reset_run: done/pass/to/fc=%b/%b/%b/%0d records=%0d, want 1/1/0/0/0",
                     done, pass, timed_out, fail_count, q_idx.size());
        end
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_halt();
        test_halt_at_limit();
        test_mismatch();
        test_care_mask();
        test_backpressure();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
